// File: rtl/exe_unit_pkg.sv
// Shared types and status-bit indices for the multi-cycle execution unit.
// The divider itself is compiled in only when EXE_DIV_EN is defined.
package exe_unit_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLT = 3'b101,
    OP_MUL = 3'b110,
    OP_DIV = 3'b111
  } oper_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int ST_Z   = 0;
  localparam int ST_N   = 1;
  localparam int ST_C   = 2;
  localparam int ST_ERR = 3;

endpackage

// File: rtl/exe_seq_muldiv.sv
// Iterative shift-add multiplier and restoring divider sharing one 2*ARG_BITS accumulator.
// The divider path exists only when EXE_DIV_EN is defined; otherwise only multiply starts are honoured.
module exe_seq_muldiv #(
  parameter int ARG_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                mode,
  input  logic [ARG_BITS-1:0] a,
  input  logic [ARG_BITS-1:0] b,
  output logic                done,
  output logic [ARG_BITS-1:0] result,
  output logic                hi_nonzero,
  output logic                div_zero
);
  localparam int CW = $clog2(ARG_BITS + 1);

  logic [CW-1:0]         cnt;
  logic [2*ARG_BITS-1:0] acc;
  logic [ARG_BITS-1:0]   opa;
  logic [ARG_BITS:0]     mul_sum;
  logic [2*ARG_BITS-1:0] mul_next;
  logic [2*ARG_BITS-1:0] step_next;
  logic [ARG_BITS-1:0]   init_lo;
  logic                  go;

  // Multiply: low half starts as B and shifts out; A is added into the high half.
  assign mul_sum  = {1'b0, acc[2*ARG_BITS-1:ARG_BITS]} + {1'b0, opa};
  assign mul_next = acc[0] ? {mul_sum, acc[ARG_BITS-1:1]} : {1'b0, acc[2*ARG_BITS-1:1]};

`ifdef EXE_DIV_EN
  logic                div_q;
  logic [ARG_BITS-1:0] opb;
  logic [ARG_BITS:0]   shifted;
  logic [ARG_BITS:0]   trial;
  logic                ge;
  logic [2*ARG_BITS-1:0] div_next;

  // Divide: high half is the partial remainder, low half shifts A out and quotient bits in.
  assign shifted  = acc[2*ARG_BITS-1:ARG_BITS-1];
  assign trial    = shifted - {1'b0, opb};
  assign ge       = (shifted >= {1'b0, opb});
  assign div_next = {(ge ? trial[ARG_BITS-1:0] : shifted[ARG_BITS-1:0]), acc[ARG_BITS-2:0], ge};

  assign go        = start;
  assign init_lo   = mode ? a : b;
  assign step_next = div_q ? div_next : mul_next;
  assign div_zero  = div_q && (opb == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= 1'b0;
      opb   <= '0;
    end else if (go) begin
      div_q <= mode;
      opb   <= b;
    end
  end
`else
  assign go        = start && !mode;
  assign init_lo   = b;
  assign step_next = mul_next;
  assign div_zero  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
      opa <= '0;
    end else if (go) begin
      cnt <= CW'(ARG_BITS);
      opa <= a;
      acc <= {{ARG_BITS{1'b0}}, init_lo};
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
      acc <= step_next;
    end
  end

  // Counter parks at zero, so the result stays put until the top level takes it.
  assign done       = (cnt == '0);
  assign result     = acc[ARG_BITS-1:0];
  assign hi_nonzero = |acc[2*ARG_BITS-1:ARG_BITS];

endmodule

// File: rtl/exe_unit_mc.sv
// Multi-cycle execution unit: single-cycle ALU, IDLE/BUSY control, valid/ready handshakes, output register.
// Define EXE_DIV_EN to compile in the sequential divider; otherwise DIV completes at once with ERR set.
module exe_unit_mc
  import exe_unit_pkg::*;
#(
  parameter int ARG_BITS = 4
) (
  input  logic                i_clk,
  input  logic                i_rsn,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [2:0]          i_oper,
  input  logic [ARG_BITS-1:0] i_argA,
  input  logic [ARG_BITS-1:0] i_argB,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [ARG_BITS-1:0] o_result,
  output logic [3:0]          o_status
);
  state_t              state;
  oper_t               oper;
  logic                busy_div;
  logic                accept, out_free, is_multi;
  logic [ARG_BITS:0]   sum, diff;
  logic [ARG_BITS-1:0] alu_res;
  logic                alu_c, alu_err;
  logic                md_done, md_hi, md_dz;
  logic [ARG_BITS-1:0] md_res;

  function automatic logic [3:0] flags(input logic [ARG_BITS-1:0] r, input logic c, input logic err);
    logic [3:0] s;
    s         = '0;
    s[ST_Z]   = (r == '0);
    s[ST_N]   = r[ARG_BITS-1];
    s[ST_C]   = c;
    s[ST_ERR] = err;
    return s;
  endfunction

  assign oper     = oper_t'(i_oper);
  assign out_free = !o_valid || i_ready;
  assign o_ready  = (state == IDLE) && out_free;
  assign accept   = i_valid && o_ready;

`ifdef EXE_DIV_EN
  assign is_multi = (oper == OP_MUL) || (oper == OP_DIV);
`else
  assign is_multi = (oper == OP_MUL);
`endif

  assign sum  = {1'b0, i_argA} + {1'b0, i_argB};
  assign diff = {1'b0, i_argA} - {1'b0, i_argB};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_err = 1'b0;
    case (oper)
      OP_ADD: begin alu_res = sum[ARG_BITS-1:0];  alu_c = sum[ARG_BITS];  end
      OP_SUB: begin alu_res = diff[ARG_BITS-1:0]; alu_c = diff[ARG_BITS]; end
      OP_AND: alu_res = i_argA & i_argB;
      OP_OR:  alu_res = i_argA | i_argB;
      OP_XOR: alu_res = i_argA ^ i_argB;
      OP_SLT: alu_res = {{(ARG_BITS-1){1'b0}}, diff[ARG_BITS]};
      OP_DIV: alu_err = 1'b1;  // only reached when the divider is not built
      default: ;
    endcase
  end

  exe_seq_muldiv #(.ARG_BITS(ARG_BITS)) u_muldiv (
    .clk        (i_clk),
    .rst_n      (i_rsn),
    .start      (accept && is_multi),
    .mode       (oper == OP_DIV),
    .a          (i_argA),
    .b          (i_argB),
    .done       (md_done),
    .result     (md_res),
    .hi_nonzero (md_hi),
    .div_zero   (md_dz)
  );

  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      state    <= IDLE;
      busy_div <= 1'b0;
      o_valid  <= 1'b0;
      o_result <= '0;
      o_status <= '0;
    end else begin
      if (o_valid && i_ready) o_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (is_multi) begin
            state    <= BUSY;
            busy_div <= (oper == OP_DIV);
          end else begin
            o_valid  <= 1'b1;
            o_result <= alu_res;
            o_status <= flags(alu_res, alu_c, alu_err);
          end
        end
        BUSY: if (md_done && out_free) begin
          state    <= IDLE;
          o_valid  <= 1'b1;
          o_result <= md_res;
          o_status <= flags(md_res, !busy_div && md_hi, busy_div && md_dz);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_unit_mc.sv
// Scoreboard bench for exe_unit_mc (ARG_BITS=4); DIV expectations follow whether EXE_DIV_EN is defined.
module tb_exe_unit_mc;
  import exe_unit_pkg::*;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         i_valid = 1'b0;
  logic         i_ready = 1'b1;
  logic [2:0]   i_oper = 3'b000;
  logic [N-1:0] arg_a = '0;
  logic [N-1:0] arg_b = '0;
  logic         o_ready, o_valid;
  logic [N-1:0] o_result;
  logic [3:0]   o_status;

  int errors = 0;
  int checks = 0;
  int last_wait = 0;
  int exp_id = 0;

  typedef struct {
    int           id;
    logic [N-1:0] r;
    logic [3:0]   s;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  exe_unit_mc #(.ARG_BITS(N)) dut (
    .i_clk    (clk),
    .i_rsn    (rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_oper   (i_oper),
    .i_argA   (arg_a),
    .i_argB   (arg_b),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_status (o_status)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Monitor: every consumed result must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got result %0d status %0d with nothing pending", o_result, o_status);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("result[%0d]", e.id), o_result, e.r);
          check($sformatf("status[%0d]", e.id), o_status, e.s);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [N-1:0] va, input logic [N-1:0] vb,
                       input logic [N-1:0] er, input logic [3:0] es);
    int w;
    w = 0;
    i_valid = 1'b1; i_oper = op; arg_a = va; arg_b = vb;
    @(negedge clk);
    while (!o_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    last_wait = w;
    if (!o_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got o_ready=0 want 1 for op %0d", op);
    end else begin
      exp_id++;
      exp_q.push_back('{exp_id, er, es});
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  // want_j = edges after the accepting edge until o_valid shows.
  task automatic issue_timed(input logic [2:0] op, input logic [N-1:0] va, input logic [N-1:0] vb,
                             input logic [N-1:0] er, input logic [3:0] es, input int want_j);
    int j;
    logic rdy_bad;
    j = 0;
    rdy_bad = 1'b0;
    issue(op, va, vb, er, es);
    @(negedge clk);
    while (!o_valid && j < 20) begin
      if (o_ready) rdy_bad = 1'b1;
      @(negedge clk);
      j++;
    end
    check($sformatf("latency_op%0d", op), j, want_j);
    check($sformatf("ready_low_busy_op%0d", op), rdy_bad, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic stale;
    #1 rst_n = 1'b0;
    #2;
    check("rst_valid", o_valid, 1'b0);
    check("rst_result", o_result, 4'd0);
    check("rst_status", o_status, 4'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", o_ready, 1'b1);
    @(posedge clk); #1;

    issue_timed(OP_ADD, 4'd9, 4'd8, 4'd1, 4'b0100, 0);
    issue(OP_SUB, 4'd3, 4'd5, 4'd14, 4'b0110);
    issue(OP_SUB, 4'd5, 4'd5, 4'd0, 4'b0001);
    check("b2b_accept_sub", last_wait, 0);
    issue(OP_OR, 4'd5, 4'd10, 4'd15, 4'b0010);
    check("b2b_accept_or", last_wait, 0);
    issue(OP_SLT, 4'd3, 4'd5, 4'd1, 4'b0000);
    issue(OP_SLT, 4'd5, 4'd3, 4'd0, 4'b0001);
    @(posedge clk); #1;

    issue_timed(OP_MUL, 4'd5, 4'd3, 4'd15, 4'b0010, N + 1);
    issue_timed(OP_MUL, 4'd5, 4'd4, 4'd4, 4'b0100, N + 1);
`ifdef EXE_DIV_EN
    issue_timed(OP_DIV, 4'd13, 4'd4, 4'd3, 4'b0000, N + 1);
    issue_timed(OP_DIV, 4'd7, 4'd0, 4'd15, 4'b1010, N + 1);
`else
    issue_timed(OP_DIV, 4'd13, 4'd4, 4'd0, 4'b1001, 0);
    issue_timed(OP_DIV, 4'd7, 4'd0, 4'd0, 4'b1001, 0);
`endif

    // Backpressure: result must hold and the unit must refuse new work.
    i_ready = 1'b0;
    issue(OP_AND, 4'd12, 4'd10, 4'd8, 4'b0010);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("hold_valid_%0d", k), o_valid, 1'b1);
      check($sformatf("hold_result_%0d", k), o_result, 4'd8);
      check($sformatf("hold_status_%0d", k), o_status, 4'b0010);
      check($sformatf("hold_ready_%0d", k), o_ready, 1'b0);
    end
    @(posedge clk); #1;
    i_ready = 1'b1;
    issue(OP_XOR, 4'd12, 4'd10, 4'd6, 4'b0000);
    check("xor_accept_on_consume", last_wait, 0);
    @(negedge clk);
    check("xor_next_valid", o_valid, 1'b1);
    check("xor_next_result", o_result, 4'd6);
    @(posedge clk); #1;

    // Reset two cycles into a MUL aborts it.
    issue(OP_MUL, 4'd5, 4'd3, 4'd15, 4'b0010);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("abort_valid", o_valid, 1'b0);
    check("abort_result", o_result, 4'd0);
    check("abort_status", o_status, 4'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready", o_ready, 1'b1);
    stale = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (o_valid) stale = 1'b1;
    end
    check("no_stale_result", stale, 1'b0);
    @(posedge clk); #1;
    issue_timed(OP_ADD, 4'd1, 4'd1, 4'd2, 4'b0000, 0);

    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
